nios2system_cpu_ocimem_arbiter: RTL

Sysclk-domain arbiter that shares the CPU's single-port on-chip debug memory (OCI RAM, 256 x 32) between two requesters. The first is the JTAG debug path, driven by the `take_action_ocimem_*` strobes and `jdo` from the debug slave's sysclk half. The second is the CPU's Avalon debug-memory slave port. It returns JTAG read data in `MonDReg` with a ready/error handshake, and arbitrates round-robin when both requesters contend.

---
 rtl/nios2system_cpu_ocimem_arbiter.sv | 137 +++++++++++++
 1 files changed

// File: rtl/nios2system_cpu_ocimem_arbiter.sv
// rtl/nios2system_cpu_ocimem_arbiter.sv - OCI RAM arbiter between the JTAG debug path and the Avalon debug slave
// Round-robin on ties; reads take one extra state while RAM data returns.
module nios2system_cpu_ocimem_arbiter #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              take_action_ocimem_a,
  input  logic              take_no_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic [37:0]       jdo,
  input  logic [ADDR_W-1:0] av_address,
  input  logic              av_read,
  input  logic              av_write,
  input  logic [31:0]       av_writedata,
  input  logic [3:0]        av_byteenable,
  output logic              av_waitrequest,
  output logic [31:0]       av_readdata,
  output logic              av_readdatavalid,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_wren,
  output logic [3:0]        ram_byteen,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata,
  output logic [31:0]       MonDReg,
  output logic              monitor_ready,
  output logic              monitor_error
);

  typedef enum logic [1:0] {IDLE, JRD, ARD} state_t;

  localparam logic LG_AV   = 1'b0;
  localparam logic LG_JTAG = 1'b1;

  state_t            state, state_nx;
  logic [ADDR_W-1:0] jaddr;
  logic              jpend;
  logic              jop_wr;
  logic [31:0]       jdata;
  logic              last_grant;
  logic              j_req, a_req;
  logic              grant_j, grant_a;
  logic              unused_jdo;

  assign unused_jdo = ^{jdo[37:35], jdo[2:0]};

  assign j_req = jpend;
  assign a_req = av_read | av_write;

  // On a tie, whoever was not granted last wins.
  assign grant_j = (state == IDLE) & j_req & (~a_req | (last_grant == LG_AV));
  assign grant_a = (state == IDLE) & a_req & (~j_req | (last_grant == LG_JTAG));

  assign av_waitrequest = a_req & ~grant_a;
  assign monitor_ready  = ~jpend;

  always_comb begin
    ram_addr   = '0;
    ram_wren   = 1'b0;
    ram_byteen = 4'h0;
    ram_wdata  = 32'h0;
    state_nx   = IDLE;
    if (grant_j) begin
      ram_addr = jaddr;
      if (jop_wr) begin
        ram_wren   = 1'b1;
        ram_byteen = 4'hF;
        ram_wdata  = jdata;
      end else begin
        state_nx = JRD;
      end
    end else if (grant_a) begin
      ram_addr = av_address;
      if (av_write) begin
        ram_wren   = 1'b1;
        ram_byteen = av_byteenable;
        ram_wdata  = av_writedata;
      end else begin
        state_nx = ARD;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state            <= IDLE;
      jaddr            <= '0;
      jpend            <= 1'b0;
      jop_wr           <= 1'b0;
      jdata            <= 32'h0;
      last_grant       <= LG_AV;
      MonDReg          <= 32'h0;
      av_readdata      <= 32'h0;
      av_readdatavalid <= 1'b0;
      monitor_error    <= 1'b0;
    end else begin
      state            <= state_nx;
      av_readdatavalid <= (state == ARD);

      if (grant_j)      last_grant <= LG_JTAG;
      else if (grant_a) last_grant <= LG_AV;

      if (state == ARD) av_readdata <= ram_rdata;

      if (grant_j && jop_wr) begin
        jpend <= 1'b0;
        jaddr <= jaddr + 1'b1;
      end

      if (state == JRD) begin
        MonDReg <= ram_rdata;
        jpend   <= 1'b0;
        jaddr   <= jaddr + 1'b1;
      end

      // Strobes are only taken while nothing is pending, so they never race the completions above.
      if (take_action_ocimem_b || take_no_action_ocimem_a || take_action_ocimem_a) begin
        if (!jpend) begin
          if (take_action_ocimem_b) begin
            jpend  <= 1'b1;
            jop_wr <= 1'b1;
            jdata  <= jdo[34:3];
          end else if (take_no_action_ocimem_a) begin
            jpend  <= 1'b1;
            jop_wr <= 1'b0;
          end else begin
            jaddr         <= jdo[ADDR_W+17:18];
            monitor_error <= 1'b0;
          end
        end else begin
          monitor_error <= 1'b1;
        end
      end
    end
  end

endmodule
